// File: rtl/dice_pkg.sv
// Shared dice definitions: face range, bus widths and roller FSM encodings.
// The sum width is also what the game controller uses for its sum input.
package dice_pkg;

    localparam int DIE_W   = 3;
    localparam int SUM_W   = 4;
    localparam int STATE_W = 2;

    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    localparam logic [STATE_W-1:0] IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ROLLING = 2'd1;
    localparam logic [STATE_W-1:0] SETTLED = 2'd2;

    function automatic logic [DIE_W-1:0] die_next(input logic [DIE_W-1:0] d);
        return (d == DIE_MAX) ? DIE_MIN : d + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes the raw roll button and filters bounces shorter than DEBOUNCE_CYCLES.
// Latency: a steady level reaches rb_o 2+DEBOUNCE_CYCLES edges after first being sampled.
// No backpressure: free-running level filter.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rb_o
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic         btn_m;
    logic         btn_s;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= btn_i;
            btn_s <= btn_m;
        end
    end

    // A differing level must persist for DEBOUNCE_CYCLES consecutive cycles to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            rb_o <= 1'b0;
        end else if (btn_s == rb_o) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            rb_o <= btn_s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dice_roller.sv
// Debounces the roll button and spins two cascaded 1..6 dice while roll_i is high.
// Latency: dice step each roll_i cycle; sum_o is combinational; sum_valid_o one cycle after roll_i falls.
// No backpressure: roll_i is a level request from the game controller.
module dice_roller
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_i,
    input  logic             roll_i,
    output logic             rb_o,
    output logic [DIE_W-1:0] die1_o,
    output logic [DIE_W-1:0] die2_o,
    output logic [SUM_W-1:0] sum_o,
    output logic             sum_valid_o,
    output logic [CNT_W-1:0] roll_count_o
);

    logic [STATE_W-1:0] state;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_i(btn_i),
        .rb_o (rb_o)
    );

    // die2 only advances when die1 wraps, giving a 36-cycle joint period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            die1_o <= DIE_MIN;
            die2_o <= DIE_MIN;
        end else if (roll_i) begin
            die1_o <= die_next(die1_o);
            if (die1_o == DIE_MAX) begin
                die2_o <= die_next(die2_o);
            end
        end
    end

    // Kept combinational so the controller sees the final sum in the cycle roll_i drops.
    assign sum_o = {1'b0, die1_o} + {1'b0, die2_o};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            roll_count_o <= '0;
        end else begin
            case (state)
                IDLE:    if (roll_i) state <= ROLLING;
                ROLLING: begin
                    if (!roll_i) begin
                        state <= SETTLED;
                        if (roll_count_o != {CNT_W{1'b1}}) begin
                            roll_count_o <= roll_count_o + 1'b1;
                        end
                    end
                end
                SETTLED: if (roll_i) state <= ROLLING;
                default: state <= IDLE;
            endcase
        end
    end

    assign sum_valid_o = (state == SETTLED);

endmodule

// File: tb/tb_dice_roller.sv
// Randomized and directed checks of dice_roller against a behavioural model
// (dice derived from total spin count, debounce from a sliding window of button samples).
module tb_dice_roller;

    localparam int DC    = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             btn_i;
    logic             roll_i;
    logic             rb_o;
    logic [2:0]       die1_o;
    logic [2:0]       die2_o;
    logic [3:0]       sum_o;
    logic             sum_valid_o;
    logic [CNT_W-1:0] roll_count_o;

    dice_roller #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn_i),
        .roll_i      (roll_i),
        .rb_o        (rb_o),
        .die1_o      (die1_o),
        .die2_o      (die2_o),
        .sum_o       (sum_o),
        .sum_valid_o (sum_valid_o),
        .roll_count_o(roll_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    bit hist[$];
    bit rb_m;
    int spins;
    int rolls_m;
    bit prev_roll;
    bit valid_m;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DC + 1; i++) hist.push_back(1'b0);
        rb_m      = 1'b0;
        spins     = 0;
        rolls_m   = 0;
        prev_roll = 1'b0;
        valid_m   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int d1, d2;
        d1 = (spins % 6) + 1;
        d2 = ((spins / 6) % 6) + 1;
        chk({tag, ".rb"},    int'(rb_o),         int'(rb_m));
        chk({tag, ".die1"},  int'(die1_o),       d1);
        chk({tag, ".die2"},  int'(die2_o),       d2);
        chk({tag, ".sum"},   int'(sum_o),        d1 + d2);
        chk({tag, ".valid"}, int'(sum_valid_o),  int'(valid_m));
        chk({tag, ".count"}, int'(roll_count_o), rolls_m);
    endtask

    // One rising edge with the given inputs; model advanced and outputs compared after it.
    task automatic step(input bit b, input bit r, input string tag);
        int  j;
        bit  v;
        bit  same;
        btn_i  = b;
        roll_i = r;
        @(posedge clk);
        #1;
        hist.push_back(b);
        j = hist.size() - 1;
        v = hist[j-2];
        same = 1'b1;
        for (int k = j - (DC + 1); k <= j - 2; k++) if (hist[k] != v) same = 1'b0;
        if (same && v != rb_m) rb_m = v;
        if (r) begin
            spins++;
            valid_m = 1'b0;
        end else begin
            if (prev_roll) begin
                valid_m = 1'b1;
                if (rolls_m < (1 << CNT_W) - 1) rolls_m++;
            end
        end
        prev_roll = r;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n  = 1'b0;
        btn_i  = 1'b0;
        roll_i = 1'b0;
        #1;
        chk({tag, ".rst_rb"},    int'(rb_o),         0);
        chk({tag, ".rst_die1"},  int'(die1_o),       1);
        chk({tag, ".rst_die2"},  int'(die2_o),       1);
        chk({tag, ".rst_sum"},   int'(sum_o),        2);
        chk({tag, ".rst_valid"}, int'(sum_valid_o),  0);
        chk({tag, ".rst_count"}, int'(roll_count_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        btn_i  = 1'b0;
        roll_i = 1'b0;
        #2;
        do_reset("init");

        // Glitch of 2 cycles is filtered
        step(1, 0, "glitch"); step(1, 0, "glitch");
        for (int i = 0; i < 8; i++) begin
            step(0, 0, "glitch");
            chk("glitch_rb", int'(rb_o), 0);
        end

        // Held level appears on the 6th edge, released level leaves on the 6th edge
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, "hold");
            chk("hold_rb", int'(rb_o), (i >= DC + 2) ? 1 : 0);
        end
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, "rel");
            chk("rel_rb", int'(rb_o), (i >= DC + 2) ? 0 : 1);
        end

        // Cascade
        do_reset("casc");
        for (int i = 0; i < 6; i++) step(0, 1, "casc");
        chk("casc6_die1", int'(die1_o), 1);
        chk("casc6_die2", int'(die2_o), 2);
        chk("casc6_sum",  int'(sum_o),  3);
        step(0, 1, "casc");
        chk("casc7_die1", int'(die1_o), 2);
        chk("casc7_die2", int'(die2_o), 2);
        chk("casc7_sum",  int'(sum_o),  4);

        // Full 36-cycle period
        do_reset("period");
        for (int i = 0; i < 36; i++) begin
            step(0, 1, "period");
            chk("period_range", int'(sum_o >= 4'd2 && sum_o <= 4'd12), 1);
        end
        chk("period_die1", int'(die1_o), 1);
        chk("period_die2", int'(die2_o), 1);
        chk("period_sum",  int'(sum_o),  2);

        // Settle and count
        do_reset("settle");
        for (int i = 0; i < 3; i++) step(0, 1, "settle");
        chk("settle_pre_sum", int'(sum_o), 5);
        step(0, 0, "settle");
        chk("settle_valid", int'(sum_valid_o),  1);
        chk("settle_count", int'(roll_count_o), 1);
        chk("settle_sum",   int'(sum_o),        5);
        step(0, 0, "settle");
        chk("settle_hold",  int'(sum_o),        5);
        step(0, 1, "settle");
        chk("settle_drop",  int'(sum_valid_o),  0);

        // Saturation
        do_reset("sat");
        for (int i = 0; i < 260; i++) begin
            step(0, 1, "sat");
            step(0, 0, "sat");
        end
        chk("sat_count", int'(roll_count_o), 255);

        // Random button and roll traffic
        do_reset("rnd");
        begin
            bit b;
            bit r;
            int len;
            b = 1'b0;
            r = 1'b0;
            for (int i = 0; i < 60; i++) begin
                len = int'($urandom_range(1, 9));
                if ($urandom_range(0, 1) == 1) b = ~b;
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 3) == 0) r = ~r;
                    step(b, r, "rnd");
                end
            end
        end

        // Asynchronous reset in the middle of a roll
        do_reset("mid");
        for (int i = 0; i < 10; i++) step(1, 1, "mid");
        #2;
        do_reset("midrst");
        step(0, 0, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
Name: dice_roller

Overview:
- Companion block to the dice-game controller. It conditions the raw roll push-button into the controller's roll-button input.
- While the controller asserts its roll request, it spins two cascaded 1..6 dice counters and presents their sum on the 4-bit sum bus the controller consumes.
- It tracks completed throws and flags when the presented sum is settled.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized button must hold a new level before rb_o follows it; must be >= 1. Simulation uses 4; the board build overrides it.
- CNT_W, 8, width of the completed-roll counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- btn_i  input  1  raw, asynchronous, bouncing roll push-button
- roll_i  input  1  roll request from the game controller (its roll output)
- rb_o  output  1  debounced roll button, feeds the controller's roll-button input
- die1_o  output  3  first die face, 1..6
- die2_o  output  3  second die face, 1..6
- sum_o  output  4  die1_o + die2_o, 2..12; feeds the controller's sum input
- sum_valid_o  output  1  high while the sum is settled after a completed roll
- roll_count_o  output  CNT_W  completed rolls, saturating

Behaviour:
- Reset values (async, rst_n=0): rb_o=0, sync flops=0, debounce count=0, die1_o=1, die2_o=1, sum_o=2, sum_valid_o=0, roll_count_o=0, FSM=IDLE. Reset mid-roll aborts immediately to these values.
- Button path:
  - btn_i passes through a 2-flop synchronizer giving btn_s.
  - When btn_s==rb_o, the count clears.
  - When btn_s!=rb_o, the count increments. When it would reach DEBOUNCE_CYCLES, rb_o<=btn_s and the count clears.
  - A btn_i level held steady therefore reaches rb_o exactly 2+DEBOUNCE_CYCLES rising edges after first being sampled.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is filtered.
- Dice counters (registered), on each edge with roll_i=1:
  - die1 <= (die1==6) ? 1 : die1+1.
  - If die1==6, then die2 <= (die2==6) ? 1 : die2+1.
  - With roll_i=0 both dice hold. Faces are never 0 or 7.
  - The (die1,die2) sequence period is 36 cycles.
- sum_o is combinational from the registered dice: zero-extend each die to 4 bits and add. There is no overflow, max 12. This matters because the controller samples sum_o in the same cycle roll_i falls.
- FSM, states IDLE, ROLLING, SETTLED:
  - IDLE: roll_i=1 -> ROLLING; else stay.
  - ROLLING: roll_i=0 -> SETTLED, and roll_count_o increments on that edge, holding at 2^CNT_W-1 once reached; else stay.
  - SETTLED: roll_i=1 -> ROLLING; else stay.
  - sum_valid_o = (state==SETTLED), registered-state decode. It rises the cycle after roll_i falls and drops the cycle after roll_i rises.
- Simultaneous events:
  - A one-cycle roll_i pulse advances die1 once, enters ROLLING, then SETTLED on the next edge, counting 1 roll.
  - btn_i activity has no direct effect on the dice; only roll_i spins them.

Decomposition:
- Shared package dice_pkg holds:
  - DIE_MIN=1, DIE_MAX=6.
  - SUM_W=4, DIE_W=3.
  - FSM state localparams IDLE=0, ROLLING=1, SETTLED=2 (2-bit).
  - The same sum width is used by the controller.
- One sub-module, btn_debounce (synchronizer + debounce counter, parameter DEBOUNCE_CYCLES, ports clk, rst_n, btn_i, rb_o), instantiated once.
- The dice counters and FSM live in dice_roller.

Test Plan:
- Glitch filter, DEBOUNCE_CYCLES=4: pulse btn_i high for 2 cycles, then low -> rb_o stays 0 throughout. Hold btn_i high 10 cycles -> rb_o rises exactly 6 edges after btn_i first sampled high. Release -> rb_o falls 6 edges after release.
- Cascade: from reset hold roll_i=1 for 6 cycles -> die1_o=1, die2_o=2, sum_o=3. Hold 1 more cycle (7 total) -> die1_o=2, die2_o=2, sum_o=4.
- Full period: roll_i=1 for 36 cycles from reset -> die1_o=1, die2_o=1, sum_o=2. Every intermediate cycle sum_o==die1_o+die2_o and is within 2..12.
- Settle/count: roll 3 cycles, drop roll_i -> sum_valid_o=1 on the next cycle, roll_count_o=1, sum_o=5 held. Raise roll_i -> sum_valid_o=0 on the next cycle.
- Saturation, CNT_W=8: 260 single-cycle roll_i pulses separated by idle cycles -> roll_count_o stops at 255.
- Reset mid-roll: roll_i=1 for 10 cycles, assert rst_n=0 asynchronously mid-cycle -> outputs immediately read die1=1, die2=1, sum=2, sum_valid=0, count=0, rb_o=0.
